spi_frame_ctrl: RTL and testbench
=================================

// Module: spi_frame_ctrl
// PURPOSE
//  Frame-level controller behind the SPI byte receiver of the RGBW controller. Consumes received bytes
//  (byte_rdy/byte_data), decodes command frames delimited by cs_n, and stages, shadows and commits the
//  four 8-bit channel levels (R,G,B,W) driven to the PWM generators. Partial, malformed or stalled
//  frames are discarded atomically, so the active levels never change mid-frame.
// PARAMETERS
//  TIMEOUT_CYC  1024   max clk cycles between bytes while cs_n low; counter width $clog2(TIMEOUT_CYC+1)
//  RST_LEVEL    8'h00  reset value of every staging/shadow/active channel register
// PORTS
//  clk        in   1  system clock
//  reset      in   1  reset, synchronous, active-high
//  cs_n       in   1  chip select, low = frame active, already synchronised to clk
//  byte_rdy   in   1  one-cycle pulse: byte_data holds a complete received byte
//  byte_data  in   8  received byte, MSB first on the wire
//  red        out  8  active red level
//  green      out  8  active green level
//  blue       out  8  active blue level
//  white      out  8  active white level
//  apply      out  1  one-cycle pulse when shadow is copied to active
//  frame_err  out  1  one-cycle pulse when a frame is discarded
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE, cs_n_q=1, all channel regs = RST_LEVEL, apply=0, frame_err=0, counters=0.
//  Frame start = cs_n falling edge (cs_n_q=1, cs_n=0); frame end = cs_n rising edge.
//  Command byte: [7:4] opcode, [3] commit flag, [1:0] channel (0=R,1=G,2=B,3=W), [2] ignored.
//   0x1: WRITE_ALL, 4 data bytes R,G,B,W.  0x2: WRITE_ONE, 1 data byte into channel [1:0].
//   0x3: COMMIT, 0 data bytes, shadow->active regardless of [3].  Other opcodes: error.
//  States: IDLE -(start)-> CMD -(byte)-> DATA|WAIT_END|ERR; DATA -(last byte)-> CSUM|WAIT_END;
//   CSUM -(byte)-> WAIT_END; WAIT_END -(end)-> IDLE with update; any -(error)-> ERR -(end)-> IDLE.
//  Data bytes land in staging regs plus a 4-bit write mask; shadow/active untouched until frame end.
//  At frame end in WAIT_END (cycle t): masked staging->shadow at t+1; if commit, shadow(new)->active
//   and apply=1 at t+1. Single-cycle latency, no other path alters red/green/blue/white.
//  Errors (frame_err=1 next cycle, staging dropped, state ERR or IDLE if end): unknown opcode; byte
//   received in WAIT_END (too many bytes); end seen in DATA/CSUM (too few); inter-byte timeout.
//  Empty frame (end while in CMD): silently back to IDLE, no frame_err.
//  Timeout counter clears on start and on every byte_rdy; counts in CMD/DATA/CSUM; reaching
//   TIMEOUT_CYC -> ERR with frame_err pulse; counter saturates, never wraps. Not counted in WAIT_END.
//  ERR ignores all bytes until cs_n high; only one frame_err per frame.
//  byte_rdy in IDLE (no start seen, incl. after reset mid-frame): ignored.
//  byte_rdy coincident with cs_n rising: byte processed first, then end evaluated with it counted.
//  byte_rdy coincident with start: start taken, byte treated as the command byte.
// CONFIGURATION
//  CHECKSUM_EN defined: every frame carries one trailing byte = XOR of command and data bytes (state
//   CSUM); mismatch -> frame_err, nothing applied. COMMIT frame is then 0x3X + checksum (2 bytes).
//  CHECKSUM_EN undefined: no CSUM state, no trailing byte; a trailing byte counts as too many.
// TESTING
//  (no CHECKSUM_EN) frame 18 FF 80 40 00, cs_n high -> R/G/B/W=FF/80/40/00, apply 1 cycle, no err.
//  frame 22 55 then frame 30 -> blue unchanged after first frame, blue=55 + apply after second.
//  frame 18 FF 80 then cs_n high -> frame_err 1 cycle, all outputs unchanged, no apply.
//  frame 12, idle TIMEOUT_CYC cycles, then 33 -> frame_err once, byte ignored, IDLE after cs_n high.
//  frame 70 -> frame_err; empty frame (cs_n low/high, no bytes) -> no frame_err, busy back to 0.
//  (CHECKSUM_EN) frame 28 55 7D -> red=55 + apply; frame 28 55 7C -> frame_err, red unchanged.
//  reset asserted after 18 FF -> outputs=RST_LEVEL; remaining bytes of that frame ignored.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// spi_frame_ctrl
// ----------------------------------------------------------------------------
// Frame-level controller behind the SPI byte receiver of the RGBW controller.
// Decodes command frames delimited by cs_n and moves the four channel levels
// through three register sets:
//   staging -> shadow : masked copy at a clean frame end
//   shadow  -> active : at a clean frame end that carries the commit flag
// Partial, malformed or stalled frames are dropped as a whole. The active
// levels therefore never change part way through a frame.
//
// Command byte: [7:4] opcode, [3] commit, [2] unused, [1:0] channel (R,G,B,W)
//   0x1 WRITE_ALL (4 data bytes), 0x2 WRITE_ONE (1 data byte), 0x3 COMMIT.
//
// Optional feature: define CHECKSUM_EN to enable it. Each frame then carries
// one trailing byte, which is the XOR of the command byte and the data bytes.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   cs_n       in   1  chip select (low = frame), already synchronised to clk
//   byte_rdy   in   1  one-cycle strobe: byte_data holds a received byte
//   byte_data  in   8  received byte
//   red/green/blue/white out 8  active channel levels
//   apply      out  1  one-cycle pulse when shadow is copied to active
//   frame_err  out  1  one-cycle pulse when a frame is discarded
//   busy       out  1  high whenever the frame FSM is not idle
// ============================================================================
module spi_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [7:0]  RST_LEVEL   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       byte_rdy,
    input  logic [7:0] byte_data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic       apply,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_ONE = TW'(1);

    localparam logic [3:0] OP_WR_ALL = 4'h1;
    localparam logic [3:0] OP_WR_ONE = 4'h2;
    localparam logic [3:0] OP_COMMIT = 4'h3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_DATA     = 3'd2,
        S_WAIT_END = 3'd3,
        S_ERR      = 3'd4
`ifdef CHECKSUM_EN
        , S_CSUM   = 3'd5
`endif
    } state_t;

    // State entered once the payload is complete. With checksums enabled,
    // the trailing checksum byte is still to come at that point.
`ifdef CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_WAIT_END;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic            r_cs_n_q;
    logic            r_armed;      // cs_n has been seen high since reset
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_op_all;     // current frame is WRITE_ALL
    logic [1:0]      r_chan;
    logic            r_commit;
    logic [1:0]      r_dcnt;       // data bytes received so far (WRITE_ALL)
    logic [3:0][7:0] r_stage;
    logic [3:0]      r_mask;
    logic [3:0][7:0] r_shadow;
    logic [3:0][7:0] r_active;
    logic            r_apply;
    logic            r_frame_err;
`ifdef CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    state_t          w_eff_state;  // state with a start in this cycle folded in
    state_t          w_s1;         // state after this cycle's byte
    state_t          w_state_nxt;
    logic            w_start;
    logic            w_end;
    logic            w_counted;
    logic            w_tmo;
    logic            w_err;
    logic            w_update;
    logic            w_cmd_take;
    logic            w_data_take;
    logic            w_last;
    logic            w_commit_eff;
    logic [1:0]      w_idx;
    logic [3:0][7:0] w_stage_nxt;
    logic [3:0]      w_mask_wr;
    logic [3:0][7:0] w_shadow_nxt;

    // After a reset taken mid-frame, cs_n must be seen high before the next
    // falling edge is accepted as a frame start. Until then the tail of the
    // interrupted frame is ignored.
    assign w_start = r_armed & r_cs_n_q & ~cs_n;
    assign w_end   = ~r_cs_n_q & cs_n;
    assign w_tmo   = (r_tmo_cnt == TMO_MAX);
    assign w_last  = r_op_all ? (r_dcnt == 2'd3) : 1'b1;
    assign w_idx   = r_op_all ? r_dcnt : r_chan;

    // The commit flag arrives with the command byte. A one-byte frame can end
    // in the same cycle as that byte, so the flag is bypassed in that case.
    assign w_commit_eff = w_cmd_take
                        ? ((byte_data[7:4] == OP_COMMIT) | byte_data[3])
                        : r_commit;

    // Select the states in which the inter-byte timeout runs.
    always_comb begin
        w_counted = 1'b0;
        case (r_state)
            S_CMD:   w_counted = 1'b1;
            S_DATA:  w_counted = 1'b1;
`ifdef CHECKSUM_EN
            S_CSUM:  w_counted = 1'b1;
`endif
            default: w_counted = 1'b0;
        endcase
    end

    // Compute the next state. Order: start, then timeout or byte, then frame end.
    always_comb begin
        w_eff_state = r_state;
        w_s1        = r_state;
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_update    = 1'b0;
        w_cmd_take  = 1'b0;
        w_data_take = 1'b0;

        // A byte that arrives with the start is the command byte.
        if ((r_state == S_IDLE) && w_start) begin
            w_eff_state = S_CMD;
        end else begin
            w_eff_state = r_state;
        end

        if (w_counted && w_tmo) begin
            w_s1  = S_ERR;
            w_err = 1'b1;
        end else if (byte_rdy) begin
            case (w_eff_state)
                S_CMD: begin
                    w_cmd_take = 1'b1;
                    case (byte_data[7:4])
                        OP_WR_ALL: w_s1 = S_DATA;
                        OP_WR_ONE: w_s1 = S_DATA;
                        OP_COMMIT: w_s1 = S_TAIL;
                        default: begin
                            w_s1  = S_ERR;
                            w_err = 1'b1;
                        end
                    endcase
                end
                S_DATA: begin
                    w_data_take = 1'b1;
                    if (w_last) begin
                        w_s1 = S_TAIL;
                    end else begin
                        w_s1 = S_DATA;
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (byte_data == r_csum) begin
                        w_s1 = S_WAIT_END;
                    end else begin
                        w_s1  = S_ERR;
                        w_err = 1'b1;
                    end
                end
`endif
                S_WAIT_END: begin
                    // The frame has more bytes than its command allows.
                    w_s1  = S_ERR;
                    w_err = 1'b1;
                end
                default: w_s1 = w_eff_state;
            endcase
        end else begin
            w_s1 = w_eff_state;
        end

        // Frame end is evaluated after any byte in the same cycle has been counted.
        if (w_end) begin
            w_state_nxt = S_IDLE;
            case (w_s1)
                S_WAIT_END: w_update = 1'b1;
                S_DATA:     w_err    = 1'b1;
`ifdef CHECKSUM_EN
                S_CSUM:     w_err    = 1'b1;
`endif
                default:    w_update = 1'b0;
            endcase
        end else begin
            w_state_nxt = w_s1;
        end
    end

    // Merge this cycle's data byte into staging and build the shadow candidate.
    always_comb begin
        w_stage_nxt  = r_stage;
        w_mask_wr    = r_mask;
        w_shadow_nxt = r_shadow;

        if (w_start || w_err) begin
            w_mask_wr = 4'b0000;
        end else begin
            w_mask_wr = r_mask;
        end

        if (w_data_take) begin
            w_stage_nxt[w_idx] = byte_data;
            w_mask_wr[w_idx]   = 1'b1;
        end else begin
            w_stage_nxt = r_stage;
        end

        for (int i = 0; i < 4; i++) begin
            if (w_mask_wr[i]) begin
                w_shadow_nxt[i] = w_stage_nxt[i];
            end else begin
                w_shadow_nxt[i] = r_shadow[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state register and cs_n edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cs_n_q <= 1'b1;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cs_n_q <= cs_n;
            r_armed  <= r_armed | cs_n;
        end
    end

    // Saturating inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_start || byte_rdy || !w_counted) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != TMO_MAX) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    // Fields latched from the command byte, plus the data byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_all <= 1'b0;
            r_chan   <= 2'd0;
            r_commit <= 1'b0;
            r_dcnt   <= 2'd0;
        end else if (w_cmd_take) begin
            r_op_all <= (byte_data[7:4] == OP_WR_ALL);
            r_chan   <= byte_data[1:0];
            r_commit <= (byte_data[7:4] == OP_COMMIT) | byte_data[3];
            r_dcnt   <= 2'd0;
        end else if (w_data_take) begin
            r_dcnt   <= r_dcnt + 2'd1;
        end else begin
            r_dcnt   <= r_dcnt;
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR over the command byte and the data bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if (w_cmd_take) begin
            r_csum <= byte_data;
        end else if (w_data_take) begin
            r_csum <= r_csum ^ byte_data;
        end else begin
            r_csum <= r_csum;
        end
    end
`endif

    // Staging registers and write mask. The mask is dropped on error or after an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= {4{RST_LEVEL}};
            r_mask  <= 4'b0000;
        end else begin
            r_stage <= w_stage_nxt;
            if (w_update) begin
                r_mask <= 4'b0000;
            end else begin
                r_mask <= w_mask_wr;
            end
        end
    end

    // Shadow and active levels plus the apply and frame_err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow    <= {4{RST_LEVEL}};
            r_active    <= {4{RST_LEVEL}};
            r_apply     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_apply     <= w_update & w_commit_eff;
            if (w_update) begin
                r_shadow <= w_shadow_nxt;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_update && w_commit_eff) begin
                r_active <= w_shadow_nxt;
            end else begin
                r_active <= r_active;
            end
        end
    end

    assign red       = r_active[0];
    assign green     = r_active[1];
    assign blue      = r_active[2];
    assign white     = r_active[3];
    assign apply     = r_apply;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for spi_frame_ctrl: a frame table plus hand-written
// sequences (end-of-frame latency, timeout, reset mid-frame, checksum).
module tb_spi_frame_ctrl;

    localparam int TMO = 1024;
    localparam int NV  = 14;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       cs_n      = 1'b1;
    logic       byte_rdy  = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] red, green, blue, white;
    logic       apply, frame_err, busy;

    int n_cmp     = 0;
    int n_bad     = 0;
    int tot_apply = 0;
    int tot_err   = 0;

    typedef struct {
        logic [0:5][7:0] b;        // frame bytes, first byte in b[0]
        int              n;
        int              csum_at;  // checksum insertion point (checksum builds)
        bit              first_coinc;
        bit              last_coinc;
        logic [31:0]     exp_lvl;  // {R,G,B,W}
        int              exp_apply;
        int              exp_err;
    } vec_t;

    vec_t vt [NV];

    spi_frame_ctrl #(.TIMEOUT_CYC(TMO), .RST_LEVEL(8'h00)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .byte_rdy(byte_rdy),
        .byte_data(byte_data), .red(red), .green(green), .blue(blue),
        .white(white), .apply(apply), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count output pulses on the falling edge.
    always @(negedge clk) begin
        if (apply === 1'b1) tot_apply++;
        if (frame_err === 1'b1) tot_err++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, required finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [47:0] bytes, input int n, input int csum_at,
                                input bit fc, input bit lc, input logic [31:0] lvl,
                                input int ap, input int er);
        vec_t v;
        v.b = bytes; v.n = n; v.csum_at = csum_at;
        v.first_coinc = fc; v.last_coinc = lc;
        v.exp_lvl = lvl; v.exp_apply = ap; v.exp_err = er;
        return v;
    endfunction

    function automatic logic [31:0] lv();
        return {red, green, blue, white};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        repeat (2) @(posedge clk);
        #1;
        byte_rdy = 1'b1; byte_data = b;
        @(posedge clk);
        #1;
        byte_rdy = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input bit hold_cs);
        logic [7:0] q [8];
        int qn;
`ifdef CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00;
`endif
        qn = 0;
        for (int i = 0; i < v.n; i++) begin
`ifdef CHECKSUM_EN
            if (i == v.csum_at) begin q[qn] = cs; qn++; end
            cs = cs ^ v.b[i];
`endif
            q[qn] = v.b[i]; qn++;
        end
`ifdef CHECKSUM_EN
        if (v.n > 0 && v.csum_at == v.n) begin q[qn] = cs; qn++; end
`endif
        @(posedge clk);
        #1;
        cs_n = 1'b0;
        for (int i = 0; i < qn; i++) begin
            if (!(i == 0 && v.first_coinc)) begin
                repeat (2) @(posedge clk);
                #1;
            end
            byte_rdy = 1'b1; byte_data = q[i];
            if (i == qn - 1 && v.last_coinc && !hold_cs) cs_n = 1'b1;
            @(posedge clk);
            #1;
            byte_rdy = 1'b0;
        end
        if (!hold_cs) begin
            if (!(qn > 0 && v.last_coinc)) begin
                repeat (2) @(posedge clk);
                #1;
                cs_n = 1'b1;
            end
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ba, be;
        //            bytes            n  csum fc lc  {R,G,B,W}     ap er
        vt[0]  = mk(48'h18FF80400000, 5, 5, 0, 0, 32'hFF804000, 1, 0);
        vt[1]  = mk(48'h225500000000, 2, 2, 0, 0, 32'hFF804000, 0, 0);
        vt[2]  = mk(48'h300000000000, 1, 1, 0, 0, 32'hFF805500, 1, 0);
        vt[3]  = mk(48'h181122000000, 3, 3, 0, 0, 32'hFF805500, 0, 1);
        vt[4]  = mk(48'h700000000000, 1, 1, 0, 0, 32'hFF805500, 0, 1);
        vt[5]  = mk(48'h000000000000, 0, 0, 0, 0, 32'hFF805500, 0, 0);
        vt[6]  = mk(48'h2199AA000000, 3, 2, 0, 0, 32'hFF805500, 0, 1);
        vt[7]  = mk(48'h300000000000, 1, 1, 0, 0, 32'hFF805500, 1, 0);
        vt[8]  = mk(48'h2B1200000000, 2, 2, 0, 1, 32'hFF805512, 1, 0);
        vt[9]  = mk(48'h2F3400000000, 2, 2, 0, 0, 32'hFF805534, 1, 0);
        vt[10] = mk(48'h100102030400, 5, 5, 1, 0, 32'hFF805534, 0, 0);
        vt[11] = mk(48'h380000000000, 1, 1, 0, 0, 32'h01020304, 1, 0);
        vt[12] = mk(48'h000000000000, 1, 1, 0, 0, 32'h01020304, 0, 1);
        vt[13] = mk(48'h2A7700000000, 2, 2, 1, 1, 32'h01027704, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_levels", lv(), 32'h00000000);
        chk("reset_apply", 32'(apply), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        for (int k = 0; k < NV; k++) begin
            ba = tot_apply; be = tot_err;
            run_frame(vt[k], 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_levels", k), lv(), vt[k].exp_lvl);
            chk($sformatf("v%0d_apply", k), 32'(tot_apply - ba), 32'(vt[k].exp_apply));
            chk($sformatf("v%0d_err", k), 32'(tot_err - be), 32'(vt[k].exp_err));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
        end

        // The level update and apply appear exactly one cycle after the frame end.
        ba = tot_apply;
        run_frame(mk(48'h2CAB00000000, 2, 2, 0, 0, 32'h0, 0, 0), 1'b1);
        chk("lat_busy_mid", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        @(negedge clk);
        chk("lat_pre_apply", 32'(apply), 32'd0);
        chk("lat_pre_red", 32'(red), 32'h01);
        @(negedge clk);
        chk("lat_apply", 32'(apply), 32'd1);
        chk("lat_levels", lv(), 32'hAB027704);
        chk("lat_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("lat_apply_width", 32'(apply), 32'd0);
        chk("lat_apply_count", 32'(tot_apply - ba), 32'd1);

        // Inter-byte timeout: one frame_err, and a late byte is ignored.
        be = tot_err; ba = tot_apply;
        run_frame(mk(48'h120000000000, 1, 255, 0, 0, 32'h0, 0, 0), 1'b1);
        @(negedge clk);
        chk("tmo_busy", 32'(busy), 32'd1);
        repeat (TMO - 8) @(negedge clk);
        chk("tmo_early", 32'(tot_err - be), 32'd0);
        repeat (16) @(negedge clk);
        chk("tmo_err", 32'(tot_err - be), 32'd1);
        chk("tmo_err_busy", 32'(busy), 32'd1);
        pulse_byte(8'h33);
        repeat (3) @(posedge clk);
        #1;
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tmo_err_once", 32'(tot_err - be), 32'd1);
        chk("tmo_no_apply", 32'(tot_apply - ba), 32'd0);
        chk("tmo_levels", lv(), 32'hAB027704);
        chk("tmo_idle", 32'(busy), 32'd0);

        // Reset in the middle of a frame; the rest of that frame is ignored.
        @(posedge clk);
        #1;
        cs_n = 1'b0;
        pulse_byte(8'h18);
        pulse_byte(8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_levels", lv(), 32'h00000000);
        chk("mrst_busy", 32'(busy), 32'd0);
        ba = tot_apply; be = tot_err;
        pulse_byte(8'h80);
        pulse_byte(8'h40);
        pulse_byte(8'h00);
        @(negedge clk);
        chk("mrst_ignored_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mrst_after_levels", lv(), 32'h00000000);
        chk("mrst_after_apply", 32'(tot_apply - ba), 32'd0);
        chk("mrst_after_err", 32'(tot_err - be), 32'd0);
        ba = tot_apply;
        run_frame(vt[0], 1'b0);
        @(negedge clk);
        chk("mrst_next_levels", lv(), 32'hFF804000);
        chk("mrst_next_apply", 32'(tot_apply - ba), 32'd1);

`ifdef CHECKSUM_EN
        // Checksum byte given explicitly: 28^55 = 7D is good, 7C is bad.
        ba = tot_apply; be = tot_err;
        run_frame(mk(48'h28557D000000, 3, 255, 0, 0, 32'h0, 0, 0), 1'b0);
        @(negedge clk);
        chk("csum_ok_levels", lv(), 32'h55804000);
        chk("csum_ok_apply", 32'(tot_apply - ba), 32'd1);
        chk("csum_ok_err", 32'(tot_err - be), 32'd0);
        ba = tot_apply; be = tot_err;
        run_frame(mk(48'h28AA7C000000, 3, 255, 0, 0, 32'h0, 0, 0), 1'b0);
        @(negedge clk);
        chk("csum_bad_levels", lv(), 32'h55804000);
        chk("csum_bad_apply", 32'(tot_apply - ba), 32'd0);
        chk("csum_bad_err", 32'(tot_err - be), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
